// File: rtl/dm_arb.sv
// dm_arb: two-port arbiter for the SISC data memory.
// Shares the single dm read/write port between the core load/store path and
// an external loader/debug port. Each access runs IDLE -> ACC -> DONE with a
// level request and a one-cycle done pulse. Ties are resolved round-robin.
// Optional feature: define DM_ARB_LOCK_EN to let the loader keep the port
// across a burst while l_lock is held.
module dm_arb #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_F,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic          c_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_we,
  input  logic [DW-1:0] dm_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;   // 0 = core, 1 = loader
  logic          r_last;    // requester served most recently
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          w_grant;
  logic          w_pick_l;
  logic          w_lock_win;

`ifdef DM_ARB_LOCK_EN
  logic r_lock;

  // Remember a loader lock seen in its DONE cycle; valid only in the next IDLE.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) r_lock <= 1'b0;
    else        r_lock <= (r_state == S_DONE) && r_owner && l_lock;
  end

  assign w_lock_win = r_lock & l_req;
`else
  logic w_unused_lock;

  assign w_unused_lock = l_lock;
  assign w_lock_win    = 1'b0;
`endif

  // State register; reset lands in IDLE at once, which also kills dm_we mid-ACC.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state, grant selection and per-state outputs.
  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_pick_l = 1'b0;
    c_gnt    = 1'b0;
    l_gnt    = 1'b0;
    c_done   = 1'b0;
    l_done   = 1'b0;
    dm_we    = 1'b0;
    busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (c_req || l_req) begin
          w_grant  = 1'b1;
          // Loader wins alone, on a tie when the core went last, or under lock.
          w_pick_l = w_lock_win | (l_req & (~c_req | ~r_last));
          w_next   = S_ACC;
        end
      end
      S_ACC: begin
        c_gnt  = ~r_owner;
        l_gnt  = r_owner;
        dm_we  = r_we;
        w_next = S_DONE;
      end
      S_DONE: begin
        // Requests are deliberately ignored here so a held req cannot retrigger.
        c_done = ~r_owner;
        l_done = r_owner;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the winner's access at grant; latch read/write data as ACC ends.
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_pick_l;
        r_we    <= w_pick_l ? l_we    : c_we;
        r_addr  <= w_pick_l ? l_addr  : c_addr;
        r_wdata <= w_pick_l ? l_wdata : c_wdata;
      end
      if (r_state == S_ACC) begin
        r_last  <= r_owner;
        r_rdata <= r_we ? r_wdata : dm_rdata;
      end
    end
  end

  assign dm_addr  = r_addr;
  assign dm_wdata = r_wdata;
  assign rdata    = r_rdata;
  assign c_stall  = c_req & ~c_done;

endmodule

// File: tb/tb_dm_arb.sv
// tb_dm_arb: directed and randomized checks of dm_arb against a
// transaction-schedule reference model and a behavioural data memory.
module tb_dm_arb;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST_F = 1'b0;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic          c_gnt, c_done, c_stall, l_gnt, l_done, dm_we, busy;
  logic [DW-1:0] rdata, dm_wdata, dm_rdata;
  logic [AW-1:0] dm_addr;

  dm_arb #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_F(RST_F),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_stall(c_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_done(l_done),
    .rdata(rdata), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .dm_rdata(dm_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural data memory: combinational read, write on the rising edge.
  logic [DW-1:0] mem [0:65535] = '{default: '0};
  assign dm_rdata = mem[dm_addr];
  always @(posedge CLK) if (dm_we) mem[dm_addr] <= dm_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a schedule of accesses. m_g is the edge that granted
  // the current access; ACC is the cycle after edge m_g, DONE after m_g+1,
  // and the next grant can come no earlier than edge m_g+3.
  logic [DW-1:0] ref_mem [0:65535] = '{default: '0};
  int            m_g, m_next;
  logic          m_last, m_owner, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
`ifdef DM_ARB_LOCK_EN
  logic          m_lock;
`endif
  int            served[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_g     = -100;
    m_next  = 0;
    m_last  = 1'b1;
    m_owner = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rdata = '0;
`ifdef DM_ARB_LOCK_EN
    m_lock  = 1'b0;
`endif
  endtask

  // Apply the arbitration rules for the upcoming edge e using current inputs.
  task automatic model_edge(input int e);
    int win;
    win = -1;
    if (e == m_g + 1) begin
      m_rdata = m_we ? m_wdata : ref_mem[m_addr];
      if (m_we) ref_mem[m_addr] = m_wdata;
    end
`ifdef DM_ARB_LOCK_EN
    if (e == m_g + 2) m_lock = m_owner & l_lock;
    if (e >= m_next && e == m_g + 3 && m_lock && l_req) win = 1;
`endif
    if (e >= m_next && win < 0) begin
      if (c_req && l_req) win = m_last ? 0 : 1;
      else if (c_req)     win = 0;
      else if (l_req)     win = 1;
    end
    if (win >= 0) begin
      m_g     = e;
      m_next  = e + 3;
      m_owner = (win == 1);
      m_last  = m_owner;
      m_we    = m_owner ? l_we    : c_we;
      m_addr  = m_owner ? l_addr  : c_addr;
      m_wdata = m_owner ? l_wdata : c_wdata;
      served.push_back(win);
    end
  endtask

  task automatic check_all();
    logic ia, id;
    ia = (cyc == m_g);
    id = (cyc == m_g + 1);
    chk("c_gnt",    c_gnt,    ia & ~m_owner);
    chk("l_gnt",    l_gnt,    ia &  m_owner);
    chk("dm_we",    dm_we,    ia &  m_we);
    chk("c_done",   c_done,   id & ~m_owner);
    chk("l_done",   l_done,   id &  m_owner);
    chk("busy",     busy,     ia | id);
    chk("dm_addr",  dm_addr,  m_addr);
    chk("dm_wdata", dm_wdata, m_wdata);
    chk("rdata",    rdata,    m_rdata);
    chk("c_stall",  c_stall,  c_req & ~(id & ~m_owner));
  endtask

  task automatic step();
    model_edge(cyc + 1);
    @(posedge CLK);
    cyc++;
    #1;
    check_all();
  endtask

  // Assert reset asynchronously, hold across one edge, release away from edges.
  task automatic do_reset();
    RST_F = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge CLK);
    cyc++;
    #1;
    check_all();
    RST_F = 1'b1;
  endtask

  initial begin
    int nl;
    bit got;

    // Reset values.
    #2;
    do_reset();
    chk("rst_dm_we", dm_we, 1'b0);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr",  dm_addr, 16'h0);

    // Core write of DEADBEEF to 0x0010.
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0010; c_wdata = 32'hDEADBEEF;
    step();
    chk("w_dm_we",   dm_we,   1'b1);
    chk("w_dm_addr", dm_addr, 16'h0010);
    chk("w_stall",   c_stall, 1'b1);
    chk("w_early",   c_done,  1'b0);
    step();
    chk("w_done",    c_done,  1'b1);
    chk("w_we_one",  dm_we,   1'b0);
    c_req = 1'b0;
    step();

    // Core read back from 0x0010.
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010; c_wdata = 32'h0;
    step();
    chk("r_dm_we", dm_we, 1'b0);
    step();
    chk("r_done",  c_done, 1'b1);
    chk("r_rdata", rdata,  32'hDEADBEEF);
    c_req = 1'b0;
    step();

    // Simultaneous requests right after reset: core, loader, core.
    do_reset();
    served.delete();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0030;
    repeat (8) step();
    chk("rr_count", served.size(), 3);
    if (served.size() == 3) begin
      chk("rr_first",  served[0], 0);
      chk("rr_second", served[1], 1);
      chk("rr_third",  served[2], 0);
    end
    c_req = 1'b0; l_req = 1'b0;
    repeat (2) step();

    // Reset in the ACC cycle of a loader write to 0x0020.
    do_reset();
    l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0020; l_wdata = 32'h12345678;
    step();
    chk("ra_l_gnt", l_gnt, 1'b1);
    chk("ra_dm_we", dm_we, 1'b1);
    l_req = 1'b0;
    do_reset();
    chk("ra_we_low", dm_we, 1'b0);
    chk("ra_busy",   busy,  1'b0);
    repeat (3) step();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0020;
    step();
    step();
    chk("ra_no_write", rdata, 32'h0);
    c_req = 1'b0;
    step();

    // Loader burst with l_lock while the core keeps requesting.
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0040; l_lock = 1'b1;
    nl = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (c_done) got = 1'b1;
      if (l_done) begin
        nl++;
        l_lock = (nl < 4);
        if (nl >= 4) l_req = 1'b0;
      end
    end
    chk("lock_core_served", got, 1'b1);
`ifdef DM_ARB_LOCK_EN
    chk("lock_loader_burst", nl, 4);
`else
    chk("lock_loader_burst", nl, 1);
`endif
    c_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
    repeat (2) step();

    // Core drops c_req in the ACC cycle of a read.
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    step();
    chk("drop_gnt", c_gnt, 1'b1);
    c_req = 1'b0;
    step();
    chk("drop_done",  c_done, 1'b1);
    chk("drop_rdata", rdata,  32'hDEADBEEF);
    step();
    chk("drop_idle",  busy,   1'b0);

    // Randomized traffic from both requesters.
    for (int i = 0; i < 400; i++) begin
      step();
      if (c_req && c_done && $urandom_range(3) != 0) c_req = 1'b0;
      else if (!c_req && $urandom_range(1) == 1) begin
        c_req = 1'b1; c_we = 1'($urandom_range(1));
        c_addr = 16'($urandom_range(15)); c_wdata = $urandom;
      end
      if (l_req && l_done && $urandom_range(3) != 0) l_req = 1'b0;
      else if (!l_req && $urandom_range(1) == 1) begin
        l_req = 1'b1; l_we = 1'($urandom_range(1));
        l_addr = 16'($urandom_range(15)); l_wdata = $urandom;
      end
      l_lock = 1'($urandom_range(1));
    end
    c_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
